pulpino_channel_sequencer: RTL and testbench
============================================

# pulpino_channel_sequencer

Word-level sequencer for the PULPino side of the USB↔PULPino byte channel. It accepts 32-bit read and write requests from the core's GPIO glue and arbitrates between them. It serialises each word into four toggle-handshaked byte transfers, LSB first, and tracks the channel's word-available and word-consumed toggles.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles between a byte-phase entry and the data sample or toggle; range 1..15.
- TIMEOUT_CYCLES, 255: wait limit in RD_WAIT and WR_DRAIN when the timeout feature is compiled in.

Ports:
- clk  in  1  single clock for all logic.
- reset_n_i  in  1  asynchronous, active-low reset.
- rd_req_i  in  1  read-word request; level, held until rd_ack_o.
- rd_ack_o  out  1  one-cycle pulse; rd_data_o valid from this cycle until the next read completes.
- rd_data_o  out  32  received word.
- wr_req_i  in  1  write-word request; level, held until wr_ack_o.
- wr_data_i  in  32  word to send; sampled in the grant cycle.
- wr_ack_o  out  1  one-cycle pulse.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  one-cycle pulse on timeout.
- usb_to_pulpino_data_i  in  8  current byte from the channel.
- usb_write_flicker_i  in  1  toggles when USB loads a new word.
- usb_read_flicker_i  in  1  toggles when USB consumes the PULPino word.
- pulpino_read_flicker_o  out  1  toggled once per byte consumed.
- pulpino_write_flicker_o  out  1  toggled once per byte produced.
- pulpino_to_usb_data_o  out  8  byte presented to the channel.

## Operation
- **Edge detection:** each flicker input is registered; edge = input XOR its registered copy. Inputs are synchronous to clk.
- **word_avail flag:** sticky; set on a usb_write_flicker_i edge; cleared on the RD_WAIT→RD_BYTE transition. If set and clear coincide, set wins.
- **tx_pending flag:** set when the 4th write toggle is issued; cleared on a usb_read_flicker_i edge. If set and clear coincide, set wins.
- **IDLE:**
  - Only rd_req_i high: grant read, go to RD_WAIT.
  - Only wr_req_i high: grant write, latch wr_data_i, go to WR_DRAIN.
  - Both high: grant according to the prio bit, then flip prio to the other requester. prio resets to read.
- **RD_WAIT:** when word_avail = 1, clear word_avail, set idx = 0, go to RD_BYTE.
- **RD_BYTE:** hold for SETTLE_CYCLES. On the last cycle:
  - rd_data_o[8*idx +: 8] <= usb_to_pulpino_data_i.
  - Toggle pulpino_read_flicker_o.
  - If idx = 3: pulse rd_ack_o and go to IDLE. Otherwise idx++ and stay in RD_BYTE.
- **WR_DRAIN:** when tx_pending = 0, set idx = 0, go to WR_SETUP.
- **WR_SETUP:** drive pulpino_to_usb_data_o = byte idx and hold for SETTLE_CYCLES. On the last cycle:
  - Toggle pulpino_write_flicker_o.
  - If idx = 3: set tx_pending, pulse wr_ack_o, go to IDLE. Otherwise idx++.
- pulpino_to_usb_data_o keeps its last value in IDLE.
- A request de-asserted mid-transfer is ignored; the transfer completes.
- A usb_write_flicker_i edge while word_avail is already set is absorbed; no overflow indication.

## Timing
- **Reset values:** all outputs 0; rd_data_o = 0; state IDLE; word_avail = 0; tx_pending = 0; idx = 0; prio = read.
- **Reset during a transfer:** returns to the reset values immediately. The flicker outputs return to 0, so the channel must share the same reset.
- **Grant:** the request is sampled in IDLE and the state changes on the next edge.
- **Read latency:** rd_ack_o asserts 4·SETTLE_CYCLES cycles after the RD_WAIT→RD_BYTE edge.
- **Write latency:** wr_ack_o asserts 4·SETTLE_CYCLES cycles after the WR_DRAIN→WR_SETUP edge.
- **Byte setup:** in WR_SETUP, data is stable ≥ SETTLE_CYCLES−1 cycles before its toggle and holds until the next byte phase.
- **Counters:** the settle counter reloads on every byte-phase entry. idx is 2 bits and wraps only by leaving the state.

## Configuration
- CHANNEL_TIMEOUT_EN defined:
  - A counter runs in RD_WAIT and WR_DRAIN.
  - On reaching TIMEOUT_CYCLES, the block pulses err_o and the matching ack together.
  - Both flags are left unchanged, and the block returns to IDLE.
  - On a read timeout, rd_data_o is unchanged.
- CHANNEL_TIMEOUT_EN undefined: waits are unbounded; err_o is tied to 0 and the counter is absent.

## Structure
- Package pulpino_channel_pkg holds:
  - State enum: IDLE, RD_WAIT, RD_BYTE, WR_DRAIN, WR_SETUP.
  - BYTE_W = 8 and WORD_BYTES = 4.
- Sub-module flicker_edge_detect: one registered bit per input; outputs the edge pulse. Instantiated twice.

## Test plan
- **Read:** word_avail toggle, rd_req_i, channel bytes CD, AB, 34, 12 → rd_data_o = 0x1234ABCD; 4 read toggles; rd_ack_o 8 cycles after RD_BYTE entry (SETTLE_CYCLES = 2).
- **Write:** wr_data_i = 0xFFCCDDAA → bytes AA, DD, CC, FF each stable at its toggle; wr_ack_o; tx_pending = 1.
- **Back-to-back writes:** second write stalls in WR_DRAIN until a usb_read_flicker_i toggle, then starts on the next cycle.
- **Simultaneous requests:** rd_req_i and wr_req_i both high from reset → read first, then write; repeat → write first.
- **Timeout:** CHANNEL_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, read with no word → err_o and rd_ack_o pulse together at cycle 16; rd_data_o unchanged.
- **Mid-read reset:** reset_n_i low after byte 1 → all outputs 0 asynchronously; a subsequent full read returns the correct word.

Source files
------------

// File: rtl/pulpino_channel_pkg.sv
// Shared types and constants for the PULPino-side byte channel sequencer.
package pulpino_channel_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BYTE,
        WR_DRAIN,
        WR_SETUP
    } state_e;

    typedef enum logic {
        PRIO_RD = 1'b0,
        PRIO_WR = 1'b1
    } prio_e;

endpackage

// File: rtl/pulpino_channel_sequencer_if.sv
// Core-side word request/ack bundle of the channel sequencer (slave = sequencer, master = core glue).
interface pulpino_channel_sequencer_if;
    import pulpino_channel_pkg::*;

    logic                         rd_req_i;
    logic                         rd_ack_o;
    logic [BYTE_W*WORD_BYTES-1:0] rd_data_o;
    logic                         wr_req_i;
    logic [BYTE_W*WORD_BYTES-1:0] wr_data_i;
    logic                         wr_ack_o;
    logic                         busy_o;
    logic                         err_o;

    modport slave (
        input  rd_req_i, wr_req_i, wr_data_i,
        output rd_ack_o, rd_data_o, wr_ack_o, busy_o, err_o
    );

    modport master (
        output rd_req_i, wr_req_i, wr_data_i,
        input  rd_ack_o, rd_data_o, wr_ack_o, busy_o, err_o
    );

endinterface

// File: rtl/flicker_edge_detect.sv
// Toggle-to-pulse converter: registers the flicker input and flags any change as a one-cycle edge.
module flicker_edge_detect (
    input  logic clk,
    input  logic reset_n_i,
    input  logic flicker_i,
    output logic edge_o
);

    logic flicker_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            flicker_q <= 1'b0;
        end else begin
            flicker_q <= flicker_i;
        end
    end

    assign edge_o = flicker_i ^ flicker_q;

endmodule

// File: rtl/pulpino_channel_sequencer.sv
// Arbitrates word read/write requests and moves each word as four toggle-handshaked bytes, LSB first.
// Build option CHANNEL_TIMEOUT_EN bounds the RD_WAIT/WR_DRAIN waits and pulses err_o with the ack.
module pulpino_channel_sequencer
    import pulpino_channel_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n_i,
    pulpino_channel_sequencer_if.slave core_if,
    input  logic [BYTE_W-1:0]    usb_to_pulpino_data_i,
    input  logic                 usb_write_flicker_i,
    input  logic                 usb_read_flicker_i,
    output logic                 pulpino_read_flicker_o,
    output logic                 pulpino_write_flicker_o,
    output logic [BYTE_W-1:0]    pulpino_to_usb_data_o
);

    localparam int         WORD_W      = BYTE_W * WORD_BYTES;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] IDX_LAST    = 2'(WORD_BYTES - 1);

    state_e              state_q, state_d;
    prio_e               prio_q, prio_d;
    logic [1:0]          idx_q, idx_d, idx_nxt;
    logic [3:0]          cnt_q, cnt_d;
    logic                word_avail_q, word_avail_d;
    logic                tx_pending_q, tx_pending_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
    logic                rd_flk_q, rd_flk_d, wr_flk_q, wr_flk_d;
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic                usb_wr_edge, usb_rd_edge;
    logic                settle_done, wait_expired;

    assert property (@(posedge clk) (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15) && (TIMEOUT_CYCLES >= 1));

    flicker_edge_detect u_usb_wr_edge (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .flicker_i (usb_write_flicker_i),
        .edge_o    (usb_wr_edge)
    );

    flicker_edge_detect u_usb_rd_edge (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .flicker_i (usb_read_flicker_i),
        .edge_o    (usb_rd_edge)
    );

    assign settle_done = (cnt_q == SETTLE_LAST);
    assign idx_nxt     = idx_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        word_avail_d = word_avail_q;
        tx_pending_d = tx_pending_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        rd_ack_d     = 1'b0;
        wr_ack_d     = 1'b0;
        rd_flk_d     = rd_flk_q;
        wr_flk_d     = wr_flk_q;
        tx_byte_d    = tx_byte_q;

        // Clear first so a set later in this block wins on coincidence.
        if (usb_rd_edge) tx_pending_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_if.rd_req_i && (!core_if.wr_req_i || prio_q == PRIO_RD)) begin
                    state_d = RD_WAIT;
                    if (core_if.wr_req_i) prio_d = PRIO_WR;
                end else if (core_if.wr_req_i) begin
                    state_d = WR_DRAIN;
                    wdata_d = core_if.wr_data_i;
                    if (core_if.rd_req_i) prio_d = PRIO_RD;
                end
            end
            RD_WAIT: begin
                if (word_avail_q) begin
                    word_avail_d = 1'b0;
                    idx_d        = 2'd0;
                    cnt_d        = 4'd0;
                    state_d      = RD_BYTE;
                end else if (wait_expired) begin
                    rd_ack_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_BYTE: begin
                if (settle_done) begin
                    rd_data_d[{idx_q, 3'b000} +: BYTE_W] = usb_to_pulpino_data_i;
                    rd_flk_d = ~rd_flk_q;
                    cnt_d    = 4'd0;
                    if (idx_q == IDX_LAST) begin
                        rd_ack_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_DRAIN: begin
                if (!tx_pending_q) begin
                    idx_d     = 2'd0;
                    cnt_d     = 4'd0;
                    tx_byte_d = wdata_q[BYTE_W-1:0];
                    state_d   = WR_SETUP;
                end else if (wait_expired) begin
                    wr_ack_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            WR_SETUP: begin
                if (settle_done) begin
                    wr_flk_d = ~wr_flk_q;
                    cnt_d    = 4'd0;
                    if (idx_q == IDX_LAST) begin
                        tx_pending_d = 1'b1;
                        wr_ack_d     = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d     = idx_nxt;
                        tx_byte_d = wdata_q[{idx_nxt, 3'b000} +: BYTE_W];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (usb_wr_edge) word_avail_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            prio_q       <= PRIO_RD;
            idx_q        <= 2'd0;
            cnt_q        <= 4'd0;
            word_avail_q <= 1'b0;
            tx_pending_q <= 1'b0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            rd_ack_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_flk_q     <= 1'b0;
            wr_flk_q     <= 1'b0;
            tx_byte_q    <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            word_avail_q <= word_avail_d;
            tx_pending_q <= tx_pending_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            rd_ack_q     <= rd_ack_d;
            wr_ack_q     <= wr_ack_d;
            rd_flk_q     <= rd_flk_d;
            wr_flk_q     <= wr_flk_d;
            tx_byte_q    <= tx_byte_d;
        end
    end

`ifdef CHANNEL_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    logic            in_wait;

    assign in_wait      = (state_q == RD_WAIT) || (state_q == WR_DRAIN);
    assign wait_expired = (to_cnt_q == TO_LAST);

    // Wait states only ever return to IDLE through the timeout path.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= in_wait && (state_d == IDLE);
            if (in_wait && (state_d == state_q)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign core_if.err_o = err_q;
`else
    assign wait_expired  = 1'b0;
    assign core_if.err_o = 1'b0;
`endif

    assign core_if.rd_ack_o  = rd_ack_q;
    assign core_if.rd_data_o = rd_data_q;
    assign core_if.wr_ack_o  = wr_ack_q;
    assign core_if.busy_o    = (state_q != IDLE);

    assign pulpino_read_flicker_o  = rd_flk_q;
    assign pulpino_write_flicker_o = wr_flk_q;
    assign pulpino_to_usb_data_o   = tx_byte_q;

endmodule

// File: tb/tb_pulpino_channel_sequencer.sv
// Bench for pulpino_channel_sequencer: a USB-side channel model plus a per-cycle word/byte scoreboard.
module tb_pulpino_channel_sequencer;
    import pulpino_channel_pkg::*;

    localparam int S  = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic [7:0]  usb_to_pulpino_data_i;
    logic        usb_write_flicker_i;
    logic        usb_read_flicker_i;
    logic        pulpino_read_flicker_o;
    logic        pulpino_write_flicker_o;
    logic [7:0]  pulpino_to_usb_data_o;

    pulpino_channel_sequencer_if core_if ();

    pulpino_channel_sequencer #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                     (clk),
        .reset_n_i               (reset_n_i),
        .core_if                 (core_if),
        .usb_to_pulpino_data_i   (usb_to_pulpino_data_i),
        .usb_write_flicker_i     (usb_write_flicker_i),
        .usb_read_flicker_i      (usb_read_flicker_i),
        .pulpino_read_flicker_o  (pulpino_read_flicker_o),
        .pulpino_write_flicker_o (pulpino_write_flicker_o),
        .pulpino_to_usb_data_o   (pulpino_to_usb_data_o)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] usb_word = 32'h0;
    logic [1:0]  rx_idx   = 2'd0;
    logic [31:0] exp_rd_q [$];
    logic [7:0]  exp_wr_q [$];
    logic [31:0] exp_rd_word = 32'h0;

    // Channel presents the byte selected by how many bytes PULPino has consumed so far.
    assign usb_to_pulpino_data_i = usb_word[{rx_idx, 3'b000} +: 8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Scoreboard: word-level expectations checked on every cycle.
    initial begin
        logic       prev_rflk = 1'b0, prev_wflk = 1'b0, prev_rd_ack = 1'b0;
        logic [7:0] prev_txd = 8'h0;
        int         rd_tog = 0, wr_tog = 0;
        forever begin
            @(negedge clk);
            if (!reset_n_i) begin
                check("rst_ctrl_outputs", 32'({core_if.rd_ack_o, core_if.wr_ack_o, core_if.busy_o, core_if.err_o,
                                               pulpino_read_flicker_o, pulpino_write_flicker_o}), 32'h0);
                check("rst_rd_data", core_if.rd_data_o, 32'h0);
                check("rst_tx_byte", 32'(pulpino_to_usb_data_o), 32'h0);
                rx_idx = 2'd0; rd_tog = 0; wr_tog = 0;
                exp_rd_q.delete(); exp_wr_q.delete(); exp_rd_word = 32'h0;
                prev_rflk = 1'b0; prev_wflk = 1'b0; prev_rd_ack = 1'b0; prev_txd = 8'h0;
            end else begin
                if (pulpino_read_flicker_o != prev_rflk) begin
                    rx_idx = rx_idx + 2'd1;
                    rd_tog++;
                end
                if (pulpino_write_flicker_o != prev_wflk) begin
                    if (exp_wr_q.size() == 0) fail_now("wr_toggle", "write toggle with no byte expected");
                    else check("wr_byte_at_toggle", 32'(prev_txd), 32'(exp_wr_q.pop_front()));
                    wr_tog++;
                end
                if (core_if.rd_ack_o) begin
                    check("rd_ack_single", 32'(prev_rd_ack), 32'h0);
                    if (core_if.err_o) begin
                        check("to_rd_data", core_if.rd_data_o, exp_rd_word);
                        check("to_rd_toggles", rd_tog, 0);
                    end else if (exp_rd_q.size() == 0) begin
                        fail_now("rd_ack", "read ack with no word expected");
                    end else begin
                        exp_rd_word = exp_rd_q.pop_front();
                        check("rd_word", core_if.rd_data_o, exp_rd_word);
                        check("rd_toggles", rd_tog, 4);
                    end
                    rd_tog = 0;
                end else if (!core_if.busy_o) begin
                    check("rd_data_hold", core_if.rd_data_o, exp_rd_word);
                end
                if (core_if.wr_ack_o) begin
                    check("wr_toggles", wr_tog, core_if.err_o ? 0 : 4);
                    wr_tog = 0;
                end
`ifdef CHANNEL_TIMEOUT_EN
                if (core_if.err_o) check("err_with_ack", 32'(core_if.rd_ack_o | core_if.wr_ack_o), 32'h1);
`else
                check("err_low", 32'(core_if.err_o), 32'h0);
`endif
                prev_rflk   = pulpino_read_flicker_o;
                prev_wflk   = pulpino_write_flicker_o;
                prev_rd_ack = core_if.rd_ack_o;
                prev_txd    = pulpino_to_usb_data_o;
            end
        end
    end

    task automatic load_word(input logic [31:0] w);
        usb_word = w;
        exp_rd_q.push_back(w);
        usb_write_flicker_i = ~usb_write_flicker_i;
    endtask

    task automatic set_wr(input logic [31:0] w);
        core_if.wr_data_i = w;
        for (int i = 0; i < 4; i++) exp_wr_q.push_back(w[8*i +: 8]);
    endtask

    // Holds requests until acked; reports ack cycle counts relative to the call.
    task automatic serve(output int first, output int rd_at, output int wr_at, output logic err_rd);
        int n = 0;
        first = 0; rd_at = -1; wr_at = -1; err_rd = 1'b0;
        while ((core_if.rd_req_i || core_if.wr_req_i) && n < 80) begin
            @(negedge clk);
            n++;
            if (core_if.rd_ack_o && core_if.rd_req_i) begin
                core_if.rd_req_i = 1'b0; rd_at = n; err_rd = core_if.err_o;
                if (first == 0) first = 1;
            end
            if (core_if.wr_ack_o && core_if.wr_req_i) begin
                core_if.wr_req_i = 1'b0; wr_at = n;
                if (first == 0) first = 2;
            end
        end
        if (core_if.rd_req_i || core_if.wr_req_i) begin
            fail_now("serve_bound", "request not acked within 80 cycles");
            core_if.rd_req_i = 1'b0;
            core_if.wr_req_i = 1'b0;
        end
    endtask

    initial begin
        int   first, rd_at, wr_at, seen, n;
        logic err_rd, last;
        reset_n_i = 1'b0;
        usb_write_flicker_i = 1'b0;
        usb_read_flicker_i  = 1'b0;
        core_if.rd_req_i  = 1'b0;
        core_if.wr_req_i  = 1'b0;
        core_if.wr_data_i = 32'h0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 reset_n_i = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(core_if.busy_o), 32'h0);

        // Both requests from reset: read wins, then write.
        load_word(32'h1234ABCD);
        repeat (2) @(negedge clk);
        set_wr(32'hFFCCDDAA);
        core_if.rd_req_i = 1'b1;
        core_if.wr_req_i = 1'b1;
        serve(first, rd_at, wr_at, err_rd);
        check("both1_first_is_read", first, 1);
        check("read_ack_latency", rd_at, 10);
        check("write_after_read_latency", wr_at, 20);
        check("read_word_literal", core_if.rd_data_o, 32'h1234ABCD);
        check("tx_byte_kept_in_idle", 32'(pulpino_to_usb_data_o), 32'hFF);
        check("rd_flicker_after_4", 32'(pulpino_read_flicker_o), 32'h0);

        // Back-to-back write stalls until the USB side consumes the previous word.
        @(negedge clk);
        set_wr(32'h11223344);
        core_if.wr_req_i = 1'b1;
        repeat (6) @(negedge clk);
        check("drain_busy", 32'(core_if.busy_o), 32'h1);
        check("drain_no_toggle", 32'(pulpino_write_flicker_o), 32'h0);
        check("drain_no_ack", 32'(core_if.wr_ack_o), 32'h0);
        usb_read_flicker_i = ~usb_read_flicker_i;
        serve(first, rd_at, wr_at, err_rd);
        check("b2b_write_latency", wr_at, 10);
        check("b2b_last_byte", 32'(pulpino_to_usb_data_o), 32'h11);

        // Both requests again: priority has flipped to write.
        @(negedge clk);
        usb_read_flicker_i = ~usb_read_flicker_i;
        repeat (2) @(negedge clk);
        load_word(32'hCAFEF00D);
        set_wr(32'h0BADBEEF);
        core_if.rd_req_i = 1'b1;
        core_if.wr_req_i = 1'b1;
        serve(first, rd_at, wr_at, err_rd);
        check("both2_first_is_write", first, 2);
        check("both2_write_latency", wr_at, 10);
        check("both2_read_latency", rd_at, 20);
        check("both2_read_word", core_if.rd_data_o, 32'hCAFEF00D);

        // Reset after two bytes of a read, then a clean read.
        @(negedge clk);
        load_word(32'h89ABCDEF);
        core_if.rd_req_i = 1'b1;
        seen = 0; n = 0; last = pulpino_read_flicker_o;
        while (seen < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (pulpino_read_flicker_o != last) begin
                seen++;
                last = pulpino_read_flicker_o;
            end
        end
        check("midrd_two_bytes", seen, 2);
        #2 reset_n_i = 1'b0;
        usb_write_flicker_i = 1'b0;
        usb_read_flicker_i  = 1'b0;
        core_if.rd_req_i    = 1'b0;
        #1;
        check("async_rst_ctrl", 32'({core_if.rd_ack_o, core_if.wr_ack_o, core_if.busy_o, core_if.err_o,
                                     pulpino_read_flicker_o, pulpino_write_flicker_o}), 32'h0);
        check("async_rst_rd_data", core_if.rd_data_o, 32'h0);
        check("async_rst_tx_byte", 32'(pulpino_to_usb_data_o), 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2 reset_n_i = 1'b1;
        @(negedge clk);
        load_word(32'h5A5AC3C3);
        core_if.rd_req_i = 1'b1;
        serve(first, rd_at, wr_at, err_rd);
        check("post_rst_read_latency", rd_at, 10);
        check("post_rst_read_word", core_if.rd_data_o, 32'h5A5AC3C3);

`ifdef CHANNEL_TIMEOUT_EN
        // Read with no word available times out after TO cycles in RD_WAIT.
        @(negedge clk);
        core_if.rd_req_i = 1'b1;
        serve(first, rd_at, wr_at, err_rd);
        check("timeout_ack_cycle", rd_at, TO + 1);
        check("timeout_err_with_ack", 32'(err_rd), 32'h1);
        check("timeout_rd_data_kept", core_if.rd_data_o, 32'h5A5AC3C3);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
